// File: rtl/i2s_receiver.sv
`default_nettype none
// ============================================================================
// Module   : i2s_receiver
// Purpose  : Oversamples an external I2S stream (BCLK, LRCLK, SDATA) in the
//            system clock domain and deserializes it into SAMPLE_WIDTH-bit
//            two's-complement PCM words with a left/right flag. The words
//            are presented on a single-entry valid/ready output register.
//            Nothing in this block is clocked by BCLK.
// Ports    : clk        - system clock (f_clk >= 4 x f_bclk)
//            reset_n    - asynchronous active-low reset
//            i2s_bclk   - I2S bit clock, asynchronous to clk
//            i2s_lrclk  - word select, 0 = left, 1 = right
//            i2s_sdata  - serial data, changes on BCLK falling edges
//            o_valid    - an output word is held
//            o_ready    - consumer accepts the held word
//            o_is_left  - channel of the held word
//            o_audio    - held PCM word
//            o_overrun  - one-cycle pulse when a completed word is dropped
// Revision : 1.0 - initial release
// ============================================================================
module i2s_receiver #(
  parameter int SAMPLE_WIDTH = 16,  // PCM bits captured per slot, 8..32
  parameter int SYNC_STAGES  = 2    // synchronizer depth, >= 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i2s_bclk,
  input  logic                    i2s_lrclk,
  input  logic                    i2s_sdata,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic                    o_is_left,
  output logic [SAMPLE_WIDTH-1:0] o_audio,
  output logic                    o_overrun
);

  localparam int CNT_W = $clog2(SAMPLE_WIDTH + 1);

  localparam logic [CNT_W-1:0] c_width = CNT_W'(SAMPLE_WIDTH);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

  localparam logic [1:0] c_st_sync  = 2'd0;
  localparam logic [1:0] c_st_arm   = 2'd1;
  localparam logic [1:0] c_st_shift = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  // Synchronizers and edge detection
  logic [SYNC_STAGES-1:0]  bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0]  lr_sync_q,   lr_sync_d;
  logic [SYNC_STAGES-1:0]  sd_sync_q,   sd_sync_d;
  logic                    bclk_prev_q, bclk_prev_d;
  logic                    rise_q,      rise_d;
  logic                    lr_smp_q,    lr_smp_d;
  logic                    sd_smp_q,    sd_smp_d;

  // Deserializer
  logic [1:0]              state_q,     state_d;
  logic [CNT_W-1:0]        bit_cnt_q,   bit_cnt_d;
  logic [SAMPLE_WIDTH-1:0] shift_q,     shift_d;
  logic                    slot_lr_q,   slot_lr_d;
  logic                    lr_prev_q,   lr_prev_d;

  // Output register
  logic                    valid_q,     valid_d;
  logic                    is_left_q,   is_left_d;
  logic [SAMPLE_WIDTH-1:0] audio_q,     audio_d;
  logic                    overrun_q,   overrun_d;

  logic                    w_boundary;
  logic                    w_complete;
  logic [SAMPLE_WIDTH-1:0] w_word;
  logic [SAMPLE_WIDTH-1:0] w_shifted;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic                    w_can_load;

  // --------------------------------------------------------------------------
  // Synchronize the pins and detect BCLK rising edges. The edge flag is
  // registered together with the LRCLK/SDATA samples taken on the same cycle,
  // so the deserializer always sees a matched (edge, lr, data) triple.
  // --------------------------------------------------------------------------
  always_comb begin
    bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], i2s_bclk};
    lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0],   i2s_lrclk};
    sd_sync_d   = {sd_sync_q[SYNC_STAGES-2:0],   i2s_sdata};
    bclk_prev_d = bclk_sync_q[SYNC_STAGES-1];
    rise_d      = bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
    lr_smp_d    = lr_sync_q[SYNC_STAGES-1];
    sd_smp_d    = sd_sync_q[SYNC_STAGES-1];
  end

  // --------------------------------------------------------------------------
  // Slot tracking and deserialization; everything advances only on a BCLK rise.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    slot_lr_d  = slot_lr_q;
    lr_prev_d  = lr_prev_q;
    w_complete = 1'b0;
    w_word     = '0;

    w_boundary = rise_q & (lr_smp_q != lr_prev_q);
    w_shifted  = {shift_q[SAMPLE_WIDTH-2:0], sd_smp_q};
    w_cnt_inc  = bit_cnt_q + c_one;

    if (rise_q) begin
      lr_prev_d = lr_smp_q;
      case (state_q)
        c_st_sync: begin
          if (w_boundary) begin
            slot_lr_d = lr_smp_q;
            bit_cnt_d = '0;
            state_d   = c_st_arm;
          end
        end
        c_st_arm: begin
          if (w_boundary) begin
            // A one-bit slot is not a legal stream; just restart the slot.
            slot_lr_d = lr_smp_q;
          end else begin
            shift_d   = {{(SAMPLE_WIDTH-1){1'b0}}, sd_smp_q};
            bit_cnt_d = c_one;
            state_d   = c_st_shift;
          end
        end
        c_st_shift: begin
          // The boundary rise still carries the last bit of the current slot
          // (one-bit delay), so it is shifted in before the word is closed.
          shift_d   = w_shifted;
          bit_cnt_d = w_cnt_inc;
          if ((w_cnt_inc == c_width) || w_boundary) begin
            w_complete = 1'b1;
            // Short slots are left-justified: missing LSBs become zero.
            w_word     = w_shifted << (c_width - w_cnt_inc);
          end
          if (w_boundary) begin
            slot_lr_d = lr_smp_q;
            bit_cnt_d = '0;
            state_d   = c_st_arm;
          end else if (w_cnt_inc == c_width) begin
            state_d   = c_st_done;
          end
        end
        c_st_done: begin
          if (w_boundary) begin
            slot_lr_d = lr_smp_q;
            bit_cnt_d = '0;
            state_d   = c_st_arm;
          end
        end
        default: state_d = c_st_sync;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Single-entry output register. A completed word may load while the held
  // word is being accepted; otherwise a busy register drops the new word.
  // --------------------------------------------------------------------------
  always_comb begin
    w_can_load = ~valid_q | o_ready;
    valid_d    = valid_q & ~o_ready;
    is_left_d  = is_left_q;
    audio_d    = audio_q;
    overrun_d  = 1'b0;
    if (w_complete) begin
      if (w_can_load) begin
        valid_d   = 1'b1;
        audio_d   = w_word;
        is_left_d = ~slot_lr_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      bclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      lr_smp_q    <= 1'b0;
      sd_smp_q    <= 1'b0;
      state_q     <= c_st_sync;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      slot_lr_q   <= 1'b0;
      lr_prev_q   <= 1'b0;
      valid_q     <= 1'b0;
      is_left_q   <= 1'b0;
      audio_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      lr_sync_q   <= lr_sync_d;
      sd_sync_q   <= sd_sync_d;
      bclk_prev_q <= bclk_prev_d;
      rise_q      <= rise_d;
      lr_smp_q    <= lr_smp_d;
      sd_smp_q    <= sd_smp_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      slot_lr_q   <= slot_lr_d;
      lr_prev_q   <= lr_prev_d;
      valid_q     <= valid_d;
      is_left_q   <= is_left_d;
      audio_q     <= audio_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_is_left = is_left_q;
  assign o_audio   = audio_q;
  assign o_overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_receiver
// Purpose  : Directed self-checking bench for i2s_receiver. Builds I2S bit
//            streams (BCLK = clk/8), plays them into the DUT and compares the
//            delivered words, overrun pulses and timing against hand-computed
//            expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_receiver;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i2s_bclk = 1'b0;
  logic        i2s_lrclk = 1'b0;
  logic        i2s_sdata = 1'b0;
  logic        o_ready = 1'b1;
  logic        o_valid;
  logic        o_is_left;
  logic [15:0] o_audio;
  logic        o_overrun;

  i2s_receiver dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_sdata (i2s_sdata),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_is_left (o_is_left),
    .o_audio   (o_audio),
    .o_overrun (o_overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  // Stream under construction: per-bit slot channel and data.
  bit q_lr[$];
  bit q_d[$];
  int rise_cyc [0:511];

  // Observations
  logic [16:0] rx_q[$];
  logic [16:0] exp_q[$];
  int          vrise_q[$];
  int          ovr_cnt  = 0;
  int          hold_err = 0;
  logic        prev_valid = 1'b0;
  logic        prev_acc   = 1'b0;
  logic [16:0] prev_word  = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: samples 1 time unit after the falling clk edge, when all
  // bench-driven inputs for the next rising edge are settled.
  always @(negedge clk) begin
    #1;
    if (o_valid && !prev_valid) vrise_q.push_back(cyc);
    if (prev_valid && !prev_acc && o_valid && ({o_is_left, o_audio} != prev_word)) hold_err++;
    if (o_overrun) ovr_cnt++;
    if (o_valid && o_ready) rx_q.push_back({o_is_left, o_audio});
    prev_valid = o_valid;
    prev_acc   = o_valid && o_ready;
    prev_word  = {o_is_left, o_audio};
  end

  task automatic push_slot(input bit lr, input logic [31:0] word, input int nbits, input int width);
    for (int i = 0; i < nbits; i++) begin
      q_lr.push_back(lr);
      q_d.push_back((i < width) ? word[width-1-i] : 1'b0);
    end
  endtask

  // LRCLK for bit k is the channel of bit k+1: the standard one-bit delay.
  task automatic play_range(input int start, input int stop);
    for (int k = start; k < stop; k++) begin
      @(negedge clk);
      i2s_bclk  = 1'b0;
      i2s_lrclk = (k + 1 < q_d.size()) ? q_lr[k+1] : q_lr[k];
      i2s_sdata = q_d[k];
      repeat (3) @(negedge clk);
      @(negedge clk);
      i2s_bclk    = 1'b1;
      rise_cyc[k] = cyc;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic flush();
    repeat (10) @(negedge clk);
  endtask

  task automatic clear_obs();
    rx_q.delete();
    exp_q.delete();
    vrise_q.delete();
    ovr_cnt  = 0;
    hold_err = 0;
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    reset_n   = 1'b0;
    i2s_bclk  = 1'b0;
    i2s_lrclk = 1'b0;
    i2s_sdata = 1'b0;
    o_ready   = rdy;
    repeat (3) @(negedge clk);
    clear_obs();
    q_lr.delete();
    q_d.delete();
    reset_n = 1'b1;
  endtask

  task automatic check_rx(input string tag);
    check_eq($sformatf("%s count", tag), rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check_eq($sformatf("%s word%0d", tag, i), {15'd0, rx_q[i]}, {15'd0, exp_q[i]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst o_valid",   {31'd0, o_valid},   32'd0);
    check_eq("rst o_is_left", {31'd0, o_is_left}, 32'd0);
    check_eq("rst o_audio",   {16'd0, o_audio},   32'd0);
    check_eq("rst o_overrun", {31'd0, o_overrun}, 32'd0);

    // ---------------- T1: 32-bit slots, L=8000 R=7FFF ----------------
    do_reset(1'b1);
    for (int f = 0; f < 3; f++) begin
      push_slot(1'b0, 32'h8000, 32, 16);
      push_slot(1'b1, 32'h7FFF, 32, 16);
    end
    play_range(0, q_d.size());
    flush();
    exp_q = '{17'h07FFF, 17'h18000, 17'h07FFF, 17'h18000, 17'h07FFF};
    check_rx("t1");
    // First delivered word is the right slot of frame 0: its 16th data bit is index 47.
    check_eq("t1 valid latency", (vrise_q.size() > 0) ? vrise_q[0] - rise_cyc[47] : -1, 32'd4);
    check_eq("t1 overruns", ovr_cnt, 32'd0);

    // ---------------- T2: 16-bit slots, L=1234 R=FEDC ----------------
    do_reset(1'b1);
    for (int f = 0; f < 3; f++) begin
      push_slot(1'b0, 32'h1234, 16, 16);
      push_slot(1'b1, 32'hFEDC, 16, 16);
    end
    play_range(0, q_d.size());
    flush();
    exp_q = '{17'h0FEDC, 17'h11234, 17'h0FEDC, 17'h11234, 17'h0FEDC};
    check_rx("t2");

    // ---------------- T3: 12-bit short slots ----------------
    do_reset(1'b1);
    push_slot(1'b0, 32'hABC, 12, 12);
    push_slot(1'b1, 32'h5A3, 12, 12);
    push_slot(1'b0, 32'hABC, 12, 12);
    push_slot(1'b1, 32'h5A3, 12, 12);
    push_slot(1'b0, 32'h000, 12, 12);   // its boundary closes the last right slot
    play_range(0, q_d.size());
    flush();
    exp_q = '{17'h05A30, 17'h1ABC0, 17'h05A30};
    check_rx("t3");

    // ---------------- T4: backpressure across three slots ----------------
    do_reset(1'b0);
    push_slot(1'b0, 32'h1111, 16, 16);  // discarded while syncing
    push_slot(1'b1, 32'h0A0A, 16, 16);  // A
    push_slot(1'b0, 32'h0B0B, 16, 16);  // B
    push_slot(1'b1, 32'h0C0C, 16, 16);  // C
    push_slot(1'b0, 32'h0D0D, 16, 16);  // D
    push_slot(1'b1, 32'h0E0E, 16, 16);  // E
    play_range(0, 64);
    flush();
    check_eq("t4 no transfer", rx_q.size(), 32'd0);
    check_eq("t4 held valid",  {31'd0, o_valid},   32'd1);
    check_eq("t4 held audio",  {16'd0, o_audio},   32'h0A0A);
    check_eq("t4 held left",   {31'd0, o_is_left}, 32'd0);
    check_eq("t4 overruns",    ovr_cnt, 32'd2);
    o_ready = 1'b1;
    flush();
    exp_q = '{17'h00A0A};
    check_rx("t4a");
    play_range(64, 96);
    flush();
    exp_q = '{17'h00A0A, 17'h10D0D, 17'h00E0E};
    check_rx("t4b");
    check_eq("t4 overruns end", ovr_cnt, 32'd2);
    check_eq("t4 hold stable",  hold_err, 32'd0);

    // ---------------- T5: accept and complete on the same cycle ----------------
    do_reset(1'b0);
    push_slot(1'b0, 32'h1111, 16, 16);  // discarded
    push_slot(1'b1, 32'h2222, 16, 16);  // A
    push_slot(1'b0, 32'h3333, 16, 16);  // B, last bit index 47
    play_range(0, 47);
    flush();
    check_eq("t5 A held", {16'd0, o_audio}, 32'h2222);
    fork
      play_range(47, 48);
      begin
        // rise reaches the FSM 3 clk edges after the pin; raise ready for
        // exactly the edge on which B completes.
        @(posedge i2s_bclk);
        repeat (3) @(negedge clk);
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
      end
    join
    flush();
    exp_q = '{17'h02222};
    check_rx("t5a");
    check_eq("t5 valid kept", {31'd0, o_valid},   32'd1);
    check_eq("t5 B audio",    {16'd0, o_audio},   32'h3333);
    check_eq("t5 B left",     {31'd0, o_is_left}, 32'd1);
    check_eq("t5 overruns",   ovr_cnt, 32'd0);
    o_ready = 1'b1;
    flush();
    exp_q = '{17'h02222, 17'h13333};
    check_rx("t5b");

    // ---------------- T6: asynchronous reset mid-word ----------------
    do_reset(1'b0);
    push_slot(1'b0, 32'h1111, 32, 16);  // discarded
    push_slot(1'b1, 32'h4444, 32, 16);  // A, held
    push_slot(1'b0, 32'h5555, 32, 16);  // B, interrupted by reset
    push_slot(1'b1, 32'h6666, 32, 16);  // C
    push_slot(1'b0, 32'h7777, 32, 16);  // D
    play_range(0, 72);
    flush();
    check_eq("t6 pre valid", {31'd0, o_valid}, 32'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;  // still before the next rising clk edge
    check_eq("t6 async valid",   {31'd0, o_valid},   32'd0);
    check_eq("t6 async audio",   {16'd0, o_audio},   32'd0);
    check_eq("t6 async left",    {31'd0, o_is_left}, 32'd0);
    check_eq("t6 async overrun", {31'd0, o_overrun}, 32'd0);
    repeat (2) @(negedge clk);
    clear_obs();
    o_ready = 1'b1;
    reset_n = 1'b1;
    play_range(72, 96);
    flush();
    check_eq("t6 no early word", rx_q.size(), 32'd0);
    play_range(96, 160);
    flush();
    exp_q = '{17'h06666, 17'h17777};
    check_rx("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
